countdown_timer: RTL and testbench

- Loadable mm:ss down-counter; the opposite counting direction of the stopwatch minutes/seconds chain.
- Counts a preset time down to 00:00 on a shared 1 Hz tick enable, then flags expiry.
- Sits beside the stopwatch counters and is driven by the same control FSM and tick generator.
- Outputs are binary minutes/seconds in the same 8-bit format the display path already consumes.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/mmss_down_counter.sv | 68 ++++++
 rtl/countdown_timer.sv | 134 +++++++++++++
 tb/tb_countdown_timer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/countdown slice: state encoding,
// time-field width and default field ceilings.
package stopwatch_pkg;

    localparam int TIME_W      = 8;
    localparam int DEF_MAX_MIN = 99;
    localparam int DEF_MAX_SEC = 59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic [TIME_W-1:0] clamp_field(input logic [TIME_W-1:0] v,
                                                      input logic [TIME_W-1:0] ceil_v);
        return (v > ceil_v) ? ceil_v : v;
    endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// Minutes/seconds down-counter with seconds->minutes borrow and saturation at 00:00.
// Priority inside the counter: clr > ld > dec.
module mmss_down_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_SEC = DEF_MAX_SEC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [TIME_W-1:0] ld_min,
    input  logic [TIME_W-1:0] ld_sec,
    input  logic              dec,
    output logic [TIME_W-1:0] count_min,
    output logic [TIME_W-1:0] count_sec,
    output logic              is_zero_next
);

    localparam logic [TIME_W-1:0] MAX_SEC_V = TIME_W'(MAX_SEC);

    logic [TIME_W-1:0] min_q, min_d;
    logic [TIME_W-1:0] sec_q, sec_d;
    logic [TIME_W-1:0] dec_min, dec_sec;

    // Decremented value; 00:00 maps to itself so the count can never wrap.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q != '0) begin
            dec_sec = sec_q - 1'b1;
        end else if (min_q != '0) begin
            dec_min = min_q - 1'b1;
            dec_sec = MAX_SEC_V;
        end
    end

    assign is_zero_next = (dec_min == '0) && (dec_sec == '0);

    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (clr) begin
            min_d = '0;
            sec_d = '0;
        end else if (ld) begin
            min_d = ld_min;
            sec_d = ld_sec;
        end else if (dec) begin
            min_d = dec_min;
            sec_d = dec_sec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '0;
            sec_q <= '0;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

    assign count_min = min_q;
    assign count_sec = sec_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable mm:ss countdown timer: control FSM, preset register, input clamping
// and one-cycle expiry pulse. Optional AUTO_RELOAD_EN restarts from the preset on expiry.
module countdown_timer
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int MAX_SEC = DEF_MAX_SEC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [TIME_W-1:0] load_min,
    input  logic [TIME_W-1:0] load_sec,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    output logic [TIME_W-1:0] minutes,
    output logic [TIME_W-1:0] seconds,
    output logic              running,
    output logic              expired,
    output logic [1:0]        state
);

    localparam logic [TIME_W-1:0] MAX_MIN_V = TIME_W'(MAX_MIN);
    localparam logic [TIME_W-1:0] MAX_SEC_V = TIME_W'(MAX_SEC);

    state_e            state_q, state_d;
    logic              running_q, running_d;
    logic              expired_q, expired_d;
    logic [TIME_W-1:0] preset_min_q, preset_min_d;
    logic [TIME_W-1:0] preset_sec_q, preset_sec_d;

    logic              ctr_clr, ctr_ld, ctr_dec;
    logic [TIME_W-1:0] ctr_ld_min, ctr_ld_sec;
    logic [TIME_W-1:0] cnt_min, cnt_sec;
    logic              is_zero_next;
    logic              count_zero;
    logic [TIME_W-1:0] clamp_min, clamp_sec;

    assign count_zero = (cnt_min == '0) && (cnt_sec == '0);
    assign clamp_min  = clamp_field(load_min, MAX_MIN_V);
    assign clamp_sec  = clamp_field(load_sec, MAX_SEC_V);

    // Strict priority: the highest asserted control owns the cycle, even when
    // it turns out to be ignored in the current state.
    always_comb begin
        state_d      = state_q;
        expired_d    = 1'b0;
        preset_min_d = preset_min_q;
        preset_sec_d = preset_sec_q;
        ctr_clr      = 1'b0;
        ctr_ld       = 1'b0;
        ctr_dec      = 1'b0;
        ctr_ld_min   = clamp_min;
        ctr_ld_sec   = clamp_sec;

        if (clear) begin
            ctr_clr = 1'b1;
            state_d = ST_IDLE;
        end else if (load) begin
            if (state_q != ST_RUNNING) begin
                ctr_ld       = 1'b1;
                preset_min_d = clamp_min;
                preset_sec_d = clamp_sec;
                state_d      = (state_q == ST_PAUSED) ? ST_PAUSED : ST_IDLE;
            end
        end else if (stop) begin
            if (state_q == ST_RUNNING) begin
                state_d = ST_PAUSED;
            end
        end else if (start) begin
            if ((state_q == ST_IDLE || state_q == ST_PAUSED) && !count_zero) begin
                state_d = ST_RUNNING;
            end
        end else if (tick && state_q == ST_RUNNING) begin
            ctr_dec = 1'b1;
            if (is_zero_next) begin
                expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (preset_min_q != '0 || preset_sec_q != '0) begin
                    ctr_ld     = 1'b1;
                    ctr_ld_min = preset_min_q;
                    ctr_ld_sec = preset_sec_q;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_DONE;
`endif
            end
        end

        running_d = (state_d == ST_RUNNING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
            preset_min_q <= '0;
            preset_sec_q <= '0;
        end else begin
            state_q      <= state_d;
            running_q    <= running_d;
            expired_q    <= expired_d;
            preset_min_q <= preset_min_d;
            preset_sec_q <= preset_sec_d;
        end
    end

    mmss_down_counter #(
        .MAX_SEC(MAX_SEC)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .clr          (ctr_clr),
        .ld           (ctr_ld),
        .ld_min       (ctr_ld_min),
        .ld_sec       (ctr_ld_sec),
        .dec          (ctr_dec),
        .count_min    (cnt_min),
        .count_sec    (cnt_sec),
        .is_zero_next (is_zero_next)
    );

    assign minutes = cnt_min;
    assign seconds = cnt_sec;
    assign running = running_q;
    assign expired = expired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; expectations are hand-computed and
// follow AUTO_RELOAD_EN when that macro is defined for the build.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       stop;
  logic       clear;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       running;
  logic       expired;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  countdown_timer dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .minutes  (minutes),
    .seconds  (seconds),
    .running  (running),
    .expired  (expired),
    .state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick = 0; load = 0; start = 0; stop = 0; clear = 0;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load = 1; load_min = m; load_sec = s;
    cycle();
    load = 0;
  endtask

  task automatic do_start();
    start = 1; cycle(); start = 0;
  endtask

  task automatic do_tick();
    tick = 1; cycle(); tick = 0;
  endtask

  task automatic do_clear();
    clear = 1; cycle(); clear = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); load_min = 0; load_sec = 0;
    cycle(); cycle();
    rst = 0;
    checks++;
    if ({minutes, seconds} !== 16'h0000) begin
      errors++; $display("FAIL reset_count: got %0d:%0d want 0:0", minutes, seconds);
    end
    checks++;
    if ({state, running, expired} !== {2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_flags: got state=%0d run=%0b exp=%0b want 0/0/0", state, running, expired);
    end
  endtask

  task automatic test_countdown_borrow();
    do_load(8'd1, 8'd2);
    checks++;
    if ({minutes, seconds, state} !== {8'd1, 8'd2, 2'd0}) begin
      errors++; $display("FAIL load_0102: got %0d:%0d st=%0d want 1:2 st=0", minutes, seconds, state);
    end
    do_start();
    checks++;
    if ({state, running} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL start_run: got st=%0d run=%0b want 1/1", state, running);
    end
    do_tick();
    checks++;
    if ({minutes, seconds} !== {8'd1, 8'd1}) begin
      errors++; $display("FAIL tick1_0101: got %0d:%0d want 1:1", minutes, seconds);
    end
    do_tick();
    checks++;
    if ({minutes, seconds} !== {8'd1, 8'd0}) begin
      errors++; $display("FAIL tick2_0100: got %0d:%0d want 1:0", minutes, seconds);
    end
    do_tick();
    checks++;
    if ({minutes, seconds, running, expired} !== {8'd0, 8'd59, 1'b1, 1'b0}) begin
      errors++; $display("FAIL borrow_0059: got %0d:%0d run=%0b exp=%0b want 0:59 1/0", minutes, seconds, running, expired);
    end
    do_clear();
  endtask

  task automatic test_expiry();
    do_load(8'd0, 8'd2);
    do_start();
    do_tick();
    checks++;
    if ({minutes, seconds, expired} !== {8'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL exp_tick1: got %0d:%0d exp=%0b want 0:1 0", minutes, seconds, expired);
    end
    do_tick();
`ifdef AUTO_RELOAD_EN
    checks++;
    if ({minutes, seconds, state, running, expired} !== {8'd0, 8'd2, 2'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL exp_reload: got %0d:%0d st=%0d run=%0b exp=%0b want 0:2 1/1/1", minutes, seconds, state, running, expired);
    end
    cycle();
    checks++;
    if (expired !== 1'b0) begin
      errors++; $display("FAIL exp_pulse_width: got %0b want 0", expired);
    end
`else
    checks++;
    if ({minutes, seconds, state, running, expired} !== {8'd0, 8'd0, 2'd3, 1'b0, 1'b1}) begin
      errors++; $display("FAIL exp_done: got %0d:%0d st=%0d run=%0b exp=%0b want 0:0 3/0/1", minutes, seconds, state, running, expired);
    end
    cycle();
    checks++;
    if (expired !== 1'b0) begin
      errors++; $display("FAIL exp_pulse_width: got %0b want 0", expired);
    end
    do_tick();
    do_start();
    do_tick();
    checks++;
    if ({minutes, seconds, state, expired} !== {8'd0, 8'd0, 2'd3, 1'b0}) begin
      errors++; $display("FAIL done_hold: got %0d:%0d st=%0d exp=%0b want 0:0 3/0", minutes, seconds, state, expired);
    end
`endif
    do_clear();
  endtask

  task automatic test_clamp_clear();
    do_load(8'd120, 8'd75);
    checks++;
    if ({minutes, seconds, state} !== {8'd99, 8'd59, 2'd0}) begin
      errors++; $display("FAIL clamp: got %0d:%0d st=%0d want 99:59 st=0", minutes, seconds, state);
    end
    do_clear();
    checks++;
    if ({minutes, seconds, state} !== {8'd0, 8'd0, 2'd0}) begin
      errors++; $display("FAIL clear: got %0d:%0d st=%0d want 0:0 st=0", minutes, seconds, state);
    end
    do_start();
    checks++;
    if ({state, running} !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL start_at_zero: got st=%0d run=%0b want 0/0", state, running);
    end
  endtask

  task automatic test_stop_start();
    do_load(8'd0, 8'd10);
    do_start();
    stop = 1; start = 1; tick = 1;
    cycle();
    idle_inputs();
    checks++;
    if ({minutes, seconds, state, running} !== {8'd0, 8'd10, 2'd2, 1'b0}) begin
      errors++; $display("FAIL stop_wins: got %0d:%0d st=%0d run=%0b want 0:10 2/0", minutes, seconds, state, running);
    end
    do_tick();
    checks++;
    if ({minutes, seconds} !== {8'd0, 8'd10}) begin
      errors++; $display("FAIL paused_tick: got %0d:%0d want 0:10", minutes, seconds);
    end
    do_start();
    do_tick();
    checks++;
    if ({minutes, seconds, state} !== {8'd0, 8'd9, 2'd1}) begin
      errors++; $display("FAIL resume_tick: got %0d:%0d st=%0d want 0:9 st=1", minutes, seconds, state);
    end
    stop = 1; cycle(); stop = 0;
    do_load(8'd0, 8'd20);
    checks++;
    if ({minutes, seconds, state} !== {8'd0, 8'd20, 2'd2}) begin
      errors++; $display("FAIL load_paused: got %0d:%0d st=%0d want 0:20 st=2", minutes, seconds, state);
    end
    do_clear();
  endtask

  task automatic test_reset_midcount();
    do_load(8'd5, 8'd30);
    do_start();
    do_load(8'd1, 8'd0);
    checks++;
    if ({minutes, seconds, state} !== {8'd5, 8'd30, 2'd1}) begin
      errors++; $display("FAIL load_in_run: got %0d:%0d st=%0d want 5:30 st=1", minutes, seconds, state);
    end
    #3;
    rst = 1; tick = 1;
    cycle();
    rst = 0; tick = 0;
    checks++;
    if ({minutes, seconds, state, running, expired} !== {8'd0, 8'd0, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_midcount: got %0d:%0d st=%0d run=%0b exp=%0b want 0:0 0/0/0", minutes, seconds, state, running, expired);
    end
  endtask

  task automatic test_auto_reload();
    do_load(8'd0, 8'd3);
    do_start();
    do_tick();
    do_tick();
    do_tick();
`ifdef AUTO_RELOAD_EN
    checks++;
    if ({minutes, seconds, state, running, expired} !== {8'd0, 8'd3, 2'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reload_003: got %0d:%0d st=%0d run=%0b exp=%0b want 0:3 1/1/1", minutes, seconds, state, running, expired);
    end
    do_tick();
    checks++;
    if ({minutes, seconds, expired} !== {8'd0, 8'd2, 1'b0}) begin
      errors++; $display("FAIL reload_next: got %0d:%0d exp=%0b want 0:2 0", minutes, seconds, expired);
    end
`else
    checks++;
    if ({minutes, seconds, state, running, expired} !== {8'd0, 8'd0, 2'd3, 1'b0, 1'b1}) begin
      errors++; $display("FAIL noreload_done: got %0d:%0d st=%0d run=%0b exp=%0b want 0:0 3/0/1", minutes, seconds, state, running, expired);
    end
`endif
    do_clear();
  endtask

  initial begin
    test_reset();
    test_countdown_borrow();
    test_expiry();
    test_clamp_clear();
    test_stop_start();
    test_reset_midcount();
    test_auto_reload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
